signal_router: RTL and testbench

//  Host-side front end of the RCD data path. Per clock, takes one host packet (DQ/CA/DQS/CK sample).

---
 rtl/signal_router_pkg.sv | 43 ++++
 rtl/router_fifo.sv | 70 +++++++
 rtl/signal_router.sv | 144 ++++++++++++++
 tb/tb_signal_router.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/signal_router_pkg.sv
// ---------------------------------------------------------------------------
// signal_router_pkg
//   Shared types and helpers for the host-side signal router.
//   - route_entry_t : one queued host packet plus its decoded destination
//                     (rank index and channel mask).
//   - lowest_set_idx: index of the lowest set bit of a vector (0 if none set).
//   The PKG_* constants fix the packet layout; the top-level parameters
//   default to them and must not be overridden to different values.
// ---------------------------------------------------------------------------
package signal_router_pkg;

  localparam int PKG_DQ_WIDTH     = 8;
  localparam int PKG_CA_WIDTH     = 7;
  localparam int PKG_DQS_WIDTH    = 1;
  localparam int PKG_CK_WIDTH     = 1;
  localparam int PKG_NUM_RANKS    = 2;
  localparam int PKG_NUM_CHANNELS = 2;

  // A single-rank system still carries a 1-bit rank field.
  localparam int PKG_RANK_W = (PKG_NUM_RANKS > 1) ? $clog2(PKG_NUM_RANKS) : 1;

  typedef struct packed {
    logic [PKG_DQ_WIDTH-1:0]     dq;
    logic [PKG_CA_WIDTH-1:0]     ca;
    logic [PKG_DQS_WIDTH-1:0]    dqs;
    logic [PKG_CK_WIDTH-1:0]     ck;
    logic [PKG_RANK_W-1:0]       rank;
    logic [PKG_NUM_CHANNELS-1:0] chan_mask;
  } route_entry_t;

  localparam int ROUTE_ENTRY_W = $bits(route_entry_t);

  // Scans from the top down so the last hit is the lowest set bit.
  function automatic logic [4:0] lowest_set_idx(input logic [31:0] vec);
    logic [4:0] idx;
    idx = '0;
    for (int i = 31; i >= 0; i--) begin
      if (vec[i]) idx = 5'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/router_fifo.sv
// ---------------------------------------------------------------------------
// router_fifo
//   Synchronous packet queue with registered pointers and occupancy count.
//   Head data (rd_data) is read combinationally from the read pointer, so a
//   word written in cycle N is visible and poppable in cycle N+1.
// Ports
//   clk      in   clock, posedge
//   rst      in   asynchronous active-high reset (pointers/count only)
//   push     in   write wr_data this cycle (ignored when full without pop)
//   pop      in   retire head entry this cycle (ignored when empty)
//   wr_data  in   WIDTH  entry to enqueue
//   rd_data  out  WIDTH  current head entry
//   full     out  count == DEPTH
//   empty    out  count == 0
//   count    out  $clog2(DEPTH)+1 occupancy
// ---------------------------------------------------------------------------
module router_fifo #(
  parameter int WIDTH = 20,
  parameter int DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           wr_data,
  output logic [WIDTH-1:0]           rd_data,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A push into a full queue only lands when the head leaves in the same cycle.
  assign do_push = push && (!full || do_pop);
  assign rd_data = mem[rd_ptr];

  // Power-of-two depth: pointers wrap naturally at PTR_W bits.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // Storage carries data only and is not reset.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wr_data;
  end

endmodule

// File: rtl/signal_router.sv
// ---------------------------------------------------------------------------
// signal_router
//   Host-side front end of the RCD data path. Each cycle it decodes a
//   destination (rank, channel mask) from the live configuration, queues
//   accepted host packets, dispatches the queue head to the rank/channel
//   fabric when its destination is enabled, acknowledges accepted packets
//   one cycle later and reports routing / overflow errors.
// Ports
//   clk             in   clock, posedge
//   rst             in   asynchronous active-high reset
//   host_dq         in   DQ_WIDTH      packet data
//   host_ca         in   CA_WIDTH      packet command/address
//   host_dqs        in   DQS_WIDTH     packet strobe sample
//   host_ck         in   CK_WIDTH      packet clock sample
//   host_pkt_valid  in   packet present this cycle
//   cfg_rank_en     in   NUM_RANKS     per-rank enable
//   cfg_channel_en  in   NUM_CHANNELS  per-channel enable
//   cfg_gang_mode   in   1 = broadcast to all enabled channels
//   route_ack       out  registered pulse, packet accepted last cycle
//   error_status    out  routing/overflow error (live term | sticky flag)
// ---------------------------------------------------------------------------
module signal_router
  import signal_router_pkg::*;
#(
  parameter int DQ_WIDTH     = PKG_DQ_WIDTH,
  parameter int CA_WIDTH     = PKG_CA_WIDTH,
  parameter int DQS_WIDTH    = PKG_DQS_WIDTH,
  parameter int CK_WIDTH     = PKG_CK_WIDTH,
  parameter int NUM_RANKS    = PKG_NUM_RANKS,
  parameter int NUM_CHANNELS = PKG_NUM_CHANNELS,
  parameter int FIFO_DEPTH   = 8
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [DQ_WIDTH-1:0]     host_dq,
  input  logic [CA_WIDTH-1:0]     host_ca,
  input  logic [DQS_WIDTH-1:0]    host_dqs,
  input  logic [CK_WIDTH-1:0]     host_ck,
  input  logic                    host_pkt_valid,
  input  logic [NUM_RANKS-1:0]    cfg_rank_en,
  input  logic [NUM_CHANNELS-1:0] cfg_channel_en,
  input  logic                    cfg_gang_mode,
  output logic                    route_ack,
  output logic                    error_status
);

  localparam int RANK_W = PKG_RANK_W;
  localparam int CNT_W  = $clog2(FIFO_DEPTH) + 1;

  // The queued entry layout comes from the package; overriding any width
  // parameter away from it would silently corrupt the entry packing.
  if (DQ_WIDTH != PKG_DQ_WIDTH || CA_WIDTH != PKG_CA_WIDTH ||
      DQS_WIDTH != PKG_DQS_WIDTH || CK_WIDTH != PKG_CK_WIDTH ||
      NUM_RANKS != PKG_NUM_RANKS || NUM_CHANNELS != PKG_NUM_CHANNELS) begin : g_param_check
    $error("signal_router: width parameters must match signal_router_pkg");
  end

  logic [RANK_W-1:0]          rank_sel;
  logic [NUM_CHANNELS-1:0]    chan_first;
  logic [NUM_CHANNELS-1:0]    chan_mask;
  logic [(1<<RANK_W)-1:0]     rank_en_ext;
  logic                       route_ok;
  logic                       err_now;
  logic                       accept;
  logic                       overflow;
  logic                       pop;
  logic                       full;
  logic                       empty;
  logic [CNT_W-1:0]           fifo_count;
  route_entry_t               push_entry;
  route_entry_t               head_entry;

  logic                       err_sticky;
  logic                       disp_valid;
  route_entry_t               disp_entry;
  logic                       disp_unused;

  // ---- stage p0: destination decode, dispatch and accept decisions ----
  always_comb begin
    rank_sel   = RANK_W'(lowest_set_idx(32'(cfg_rank_en)));
    chan_first = (|cfg_channel_en)
               ? (NUM_CHANNELS'(1) << lowest_set_idx(32'(cfg_channel_en)))
               : '0;
    chan_mask  = cfg_gang_mode ? cfg_channel_en : chan_first;
    route_ok   = (|cfg_rank_en) && (|cfg_channel_en);

    push_entry           = '0;
    push_entry.dq        = host_dq;
    push_entry.ca        = host_ca;
    push_entry.dqs       = host_dqs;
    push_entry.ck        = host_ck;
    push_entry.rank      = rank_sel;
    push_entry.chan_mask = chan_mask;

    // Zero-extend so any rank index the entry can hold is a legal select.
    rank_en_ext                  = '0;
    rank_en_ext[NUM_RANKS-1:0]   = cfg_rank_en;

    // The head leaves only if its own rank and at least one of its channels
    // are enabled right now; otherwise the queue backs up behind it.
    pop      = !empty && rank_en_ext[head_entry.rank] &&
               (|(head_entry.chan_mask & cfg_channel_en));
    accept   = host_pkt_valid && route_ok && (!full || pop);
    overflow = host_pkt_valid && route_ok && full && !pop;
    err_now  = host_pkt_valid && !route_ok;
  end

  router_fifo #(
    .WIDTH (ROUTE_ENTRY_W),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (accept),
    .pop     (pop),
    .wr_data (push_entry),
    .rd_data (head_entry),
    .full    (full),
    .empty   (empty),
    .count   (fifo_count)
  );

  // ---- stage p1: ack, sticky error and dispatch registers ----
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      route_ack  <= 1'b0;
      err_sticky <= 1'b0;
      disp_valid <= 1'b0;
      disp_entry <= '0;
    end else begin
      route_ack  <= accept;
      err_sticky <= err_sticky | err_now | overflow;
      disp_valid <= pop;
      if (pop) disp_entry <= head_entry;
    end
  end

  // The live term exposes a bad packet in its own cycle; held low in reset.
  assign error_status = !rst && (err_now || err_sticky);

  // The fabric taps the dispatch registers; no downstream port exists here yet.
  assign disp_unused = ^{disp_valid, disp_entry, fifo_count};

endmodule

// File: tb/tb_signal_router.sv
module tb_signal_router;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] host_dq;
  logic [6:0] host_ca;
  logic [0:0] host_dqs;
  logic [0:0] host_ck;
  logic       host_pkt_valid;
  logic [1:0] cfg_rank_en;
  logic [1:0] cfg_channel_en;
  logic       cfg_gang_mode;
  logic       route_ack;
  logic       error_status;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  signal_router dut (
    .clk            (clk),
    .rst            (rst),
    .host_dq        (host_dq),
    .host_ca        (host_ca),
    .host_dqs       (host_dqs),
    .host_ck        (host_ck),
    .host_pkt_valid (host_pkt_valid),
    .cfg_rank_en    (cfg_rank_en),
    .cfg_channel_en (cfg_channel_en),
    .cfg_gang_mode  (cfg_gang_mode),
    .route_ack      (route_ack),
    .error_status   (error_status)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    rst            = 1'b1;
    host_pkt_valid = 1'b0;
    host_dq        = 8'h00;
    host_ca        = 7'h3C;
    host_dqs       = 1'b1;
    host_ck        = 1'b0;
    cfg_rank_en    = 2'b11;
    cfg_channel_en = 2'b11;
    cfg_gang_mode  = 1'b0;

    // Reset held for two cycles
    tick(); tick();
    check("rst_ack",   route_ack,          0);
    check("rst_err",   error_status,       0);
    check("rst_count", dut.u_fifo.count,   0);
    check("rst_disp",  dut.disp_valid,     0);
    rst = 1'b0;

    // Three back-to-back packets, rank 0 / mask 01
    host_pkt_valid = 1'b1; host_dq = 8'h11;
    tick();
    check("b2b_ack1",   route_ack,        1);
    check("b2b_count1", dut.u_fifo.count, 1);
    host_dq = 8'h12;
    tick();
    check("b2b_ack2",   route_ack,               1);
    check("b2b_dvld1",  dut.disp_valid,          1);
    check("b2b_ddq1",   dut.disp_entry.dq,       8'h11);
    check("b2b_rank1",  dut.disp_entry.rank,     0);
    check("b2b_mask1",  dut.disp_entry.chan_mask, 2'b01);
    host_dq = 8'h13;
    tick();
    check("b2b_ack3",   route_ack,          1);
    check("b2b_ddq2",   dut.disp_entry.dq,  8'h12);
    check("b2b_count3", dut.u_fifo.count,   1);
    host_pkt_valid = 1'b0;
    tick();
    check("b2b_ack_off", route_ack,         0);
    check("b2b_ddq3",    dut.disp_entry.dq, 8'h13);
    check("b2b_empty",   dut.u_fifo.count,  0);
    tick();
    check("b2b_dvld_off", dut.disp_valid, 0);
    check("b2b_err",      error_status,   0);

    // Gang mode / single-channel decode
    cfg_gang_mode = 1'b1; cfg_channel_en = 2'b10; cfg_rank_en = 2'b10;
    host_pkt_valid = 1'b1; host_dq = 8'h44;
    tick();
    check("gang_ack",   route_ack,        1);
    check("gang_count", dut.u_fifo.count, 1);
    host_pkt_valid = 1'b0;
    tick();
    check("gang_ddq",  dut.disp_entry.dq,        8'h44);
    check("gang_rank", dut.disp_entry.rank,      1);
    check("gang_mask", dut.disp_entry.chan_mask, 2'b10);
    cfg_gang_mode = 1'b0; cfg_channel_en = 2'b11;
    host_pkt_valid = 1'b1; host_dq = 8'h55;
    tick();
    host_pkt_valid = 1'b0;
    tick();
    check("single_ddq",  dut.disp_entry.dq,        8'h55);
    check("single_rank", dut.disp_entry.rank,      1);
    check("single_mask", dut.disp_entry.chan_mask, 2'b01);
    cfg_gang_mode = 1'b1; cfg_rank_en = 2'b11;
    host_pkt_valid = 1'b1; host_dq = 8'h66;
    tick();
    host_pkt_valid = 1'b0;
    tick();
    check("bcast_rank", dut.disp_entry.rank,      0);
    check("bcast_mask", dut.disp_entry.chan_mask, 2'b11);
    cfg_gang_mode = 1'b0;

    // Unroutable packet: immediate error, no ack, sticky
    check("pre_err", error_status, 0);
    cfg_rank_en = 2'b00; cfg_channel_en = 2'b00;
    host_pkt_valid = 1'b1; host_dq = 8'hA5;
    #1;
    check("bad_err_now", error_status, 1);
    tick();
    check("bad_ack",   route_ack,        0);
    check("bad_count", dut.u_fifo.count, 0);
    host_pkt_valid = 1'b0; cfg_rank_en = 2'b11; cfg_channel_en = 2'b11;
    tick();
    check("bad_sticky1", error_status, 1);
    tick();
    check("bad_sticky2", error_status, 1);

    rst = 1'b1;
    #1;
    check("clr_err", error_status, 0);
    tick();
    rst = 1'b0;

    // Fill with a stalled head, overflow, then drain with push+pop at full
    cfg_rank_en = 2'b11; host_pkt_valid = 1'b1; host_dq = 8'h80;
    tick();
    cfg_rank_en = 2'b10;
    for (int i = 1; i < 8; i++) begin
      host_dq = 8'h80 + 8'(i);
      tick();
      check("fill_ack", route_ack, 1);
    end
    check("fill_count", dut.u_fifo.count, 8);
    check("fill_err",   error_status,     0);
    host_dq = 8'h88;
    #1;
    check("ovf_err_live", error_status, 0);
    tick();
    check("ovf_ack",   route_ack,        0);
    check("ovf_err",   error_status,     1);
    check("ovf_count", dut.u_fifo.count, 8);
    cfg_rank_en = 2'b11; host_dq = 8'h90;
    tick();
    check("full_pp_ack",   route_ack,         1);
    check("full_pp_count", dut.u_fifo.count,  8);
    check("full_pp_ddq",   dut.disp_entry.dq, 8'h80);
    host_pkt_valid = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      tick();
      check("drain_dvld",  dut.disp_valid,    1);
      check("drain_ddq",   dut.disp_entry.dq, (i < 8) ? (32'h80 + 32'(i)) : 32'h90);
      check("drain_count", dut.u_fifo.count,  32'(8 - i));
    end
    tick();
    check("drain_idle", dut.disp_valid, 0);

    // Reset pulse with a partially full queue
    cfg_rank_en = 2'b11; host_pkt_valid = 1'b1; host_dq = 8'hA1;
    tick();
    cfg_rank_en = 2'b10; host_dq = 8'hA2;
    tick();
    host_dq = 8'hA3;
    tick();
    check("mid_count", dut.u_fifo.count, 3);
    check("mid_ack",   route_ack,        1);
    rst = 1'b1; host_pkt_valid = 1'b0;
    #1;
    check("mid_rst_ack",   route_ack,        0);
    check("mid_rst_count", dut.u_fifo.count, 0);
    check("mid_rst_err",   error_status,     0);
    tick();
    rst = 1'b0; cfg_rank_en = 2'b11; host_pkt_valid = 1'b1; host_dq = 8'h5A;
    tick();
    check("post_ack",   route_ack,        1);
    check("post_count", dut.u_fifo.count, 1);
    check("post_err",   error_status,     0);
    host_pkt_valid = 1'b0;
    tick();
    check("post_ddq",     dut.disp_entry.dq, 8'h5A);
    check("post_ack_off", route_ack,         0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
